// File: rtl/dma_bridge_pkg.sv
// Shared types for the DMA line/word bridge: FSM states, transfer mode and words-per-line helper.
package dma_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_POP,
    LD_REQ,
    LD_WAIT,
    ST_REQ,
    ST_WAIT,
    ST_PUSH,
    DONE
  } state_t;

  typedef enum logic {
    MODE_LOAD  = 1'b0,
    MODE_STORE = 1'b1
  } mode_t;

  function automatic int unsigned wpl(input int unsigned cl, input int unsigned word);
    return cl / word;
  endfunction

endpackage

// File: rtl/dma_line_shifter.sv
// Cache-line register: load a whole line, shift out word 0 (LOAD path),
// or insert a word at a given slot (STORE path).
module dma_line_shifter
  import dma_bridge_pkg::*;
#(
  parameter  int unsigned CL_WIDTH   = 512,
  parameter  int unsigned WORD_WIDTH = 32,
  localparam int unsigned WPL        = wpl(CL_WIDTH, WORD_WIDTH),
  localparam int unsigned IDX_W      = (WPL > 1) ? $clog2(WPL) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [CL_WIDTH-1:0]   i_line,
  input  logic                  i_shift,
  input  logic                  i_ins,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [WORD_WIDTH-1:0] i_word,
  output logic [CL_WIDTH-1:0]   o_line,
  output logic [WORD_WIDTH-1:0] o_word0
);

  logic [CL_WIDTH-1:0] r_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_line;
    end else if (i_shift) begin
      r_line <= r_line >> WORD_WIDTH;
    end else if (i_ins) begin
      r_line[i_idx*WORD_WIDTH +: WORD_WIDTH] <= i_word;
    end
  end

  assign o_line  = r_line;
  assign o_word0 = r_line[WORD_WIDTH-1:0];

endmodule

// File: rtl/dma_line_word_bridge.sv
// Bridge between host DMA cache-line FIFOs and a word-wide memory port (LOAD unpacks, STORE packs).
// Optional stall_cycles counter enabled by defining DMA_BRIDGE_PERF_EN.
module dma_line_word_bridge
  import dma_bridge_pkg::*;
#(
  parameter int unsigned CL_WIDTH   = 512,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [CNT_WIDTH-1:0]  num_lines,
  input  logic [ADDR_WIDTH-1:0] mem_base,
  output logic                  busy,
  output logic                  done,
  input  logic                  dma_empty,
  input  logic [CL_WIDTH-1:0]   dma_rd_data,
  output logic                  dma_rd_en,
  input  logic                  dma_full,
  output logic [CL_WIDTH-1:0]   dma_wr_data,
  output logic                  dma_wr_en,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
`ifdef DMA_BRIDGE_PERF_EN
  , output logic [31:0]         stall_cycles
`endif
);

  localparam int unsigned WPL   = wpl(CL_WIDTH, WORD_WIDTH);
  localparam int unsigned IDX_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPL - 1);

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]  r_lines_left;
  logic [IDX_W-1:0]      r_idx;
  logic w_accept, w_ack, w_last_word, w_last_line, w_line_done;
  logic w_load, w_shift, w_ins;
  logic [WORD_WIDTH-1:0] w_word0;
  logic [CL_WIDTH-1:0]   w_line;

  assign w_accept    = (r_state == IDLE) && start;
  // mem_valid only counts while a request is outstanding, i.e. in a WAIT state
  assign w_ack       = mem_valid && ((r_state == LD_WAIT) || (r_state == ST_WAIT));
  assign w_last_word = (r_idx == LAST_IDX);
  assign w_last_line = (r_lines_left == CNT_WIDTH'(1));
  assign w_line_done = ((r_state == LD_WAIT) && mem_valid && w_last_word) ||
                       ((r_state == ST_PUSH) && !dma_full);

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    dma_rd_en = 1'b0;
    dma_wr_en = 1'b0;
    mem_en    = 1'b0;
    mem_wr_en = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_ins     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (num_lines == '0)                     w_next = DONE;
          else if (mode_t'(mode) == MODE_STORE)    w_next = ST_REQ;
          else                                     w_next = LD_POP;
        end
      end
      LD_POP: begin
        busy = 1'b1;
        if (!dma_empty) begin
          dma_rd_en = 1'b1;
          w_load    = 1'b1;
          w_next    = LD_REQ;
        end
      end
      LD_REQ: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_wr_en = 1'b1;
        w_next    = LD_WAIT;
      end
      LD_WAIT: begin
        busy = 1'b1;
        if (mem_valid) begin
          w_shift = 1'b1;
          if (!w_last_word)     w_next = LD_REQ;
          else if (w_last_line) w_next = DONE;
          else                  w_next = LD_POP;
        end
      end
      ST_REQ: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (mem_valid) begin
          w_ins  = 1'b1;
          w_next = w_last_word ? ST_PUSH : ST_REQ;
        end
      end
      ST_PUSH: begin
        busy = 1'b1;
        if (!dma_full) begin
          dma_wr_en = 1'b1;
          w_next    = w_last_line ? DONE : ST_REQ;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_lines_left <= '0;
      r_idx        <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr       <= mem_base;
        r_lines_left <= num_lines;
        r_idx        <= '0;
      end
      if (w_ack) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_idx  <= w_last_word ? '0 : r_idx + 1'b1;
      end
      if (w_line_done) r_lines_left <= r_lines_left - 1'b1;
    end
  end

  dma_line_shifter #(
    .CL_WIDTH  (CL_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_line (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_line (dma_rd_data),
    .i_shift(w_shift),
    .i_ins  (w_ins),
    .i_idx  (r_idx),
    .i_word (mem_rdata),
    .o_line (w_line),
    .o_word0(w_word0)
  );

  assign mem_addr    = r_addr;
  assign mem_wdata   = w_word0;
  assign dma_wr_data = w_line;

`ifdef DMA_BRIDGE_PERF_EN
  logic        w_stall;
  logic [31:0] r_stall;

  assign w_stall = ((r_state == LD_POP)  && dma_empty) ||
                   ((r_state == ST_PUSH) && dma_full)  ||
                   (((r_state == LD_WAIT) || (r_state == ST_WAIT)) && !mem_valid);

  always_ff @(posedge clk) begin
    if (rst)                              r_stall <= '0;
    else if (w_accept)                    r_stall <= '0;
    else if (w_stall && (r_stall != '1))  r_stall <= r_stall + 32'd1;
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_dma_line_word_bridge.sv
// Scoreboard bench for dma_line_word_bridge: memory responder, host FIFO models, request/line queues.
module tb_dma_line_word_bridge;

  localparam int unsigned CL  = 512;
  localparam int unsigned W   = 32;
  localparam int unsigned AW  = 28;
  localparam int unsigned CW  = 16;
  localparam int unsigned WPL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [CW-1:0] num_lines = '0;
  logic [AW-1:0] mem_base = '0;
  logic busy, done, dma_rd_en, dma_wr_en, mem_en, mem_wr_en;
  logic dma_empty = 1'b1, dma_full = 1'b0, mem_valid = 1'b0;
  logic [CL-1:0] dma_rd_data = '0, dma_wr_data;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata = '0;
`ifdef DMA_BRIDGE_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  dma_line_word_bridge #(
    .CL_WIDTH(CL), .WORD_WIDTH(W), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_lines(num_lines),
    .mem_base(mem_base), .busy(busy), .done(done), .dma_empty(dma_empty),
    .dma_rd_data(dma_rd_data), .dma_rd_en(dma_rd_en), .dma_full(dma_full),
    .dma_wr_data(dma_wr_data), .dma_wr_en(dma_wr_en), .mem_en(mem_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
`ifdef DMA_BRIDGE_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } req_t;

  req_t          exp_q[$];
  logic [CL-1:0] line_q[$];
  logic [CL-1:0] host_q[$];

  int n_checks = 0, n_fail = 0, cyc = 0;
  int req_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, reads_acked = 0;
  int done_cyc = 0, last_ack_cyc = 0, push_cyc = 0, start_cyc = 0;
  int p_req = 0, p_rd = 0, p_wr = 0, p_done = 0;
  int lat_cnt = 0, ack_lat = 0;
  bit pend = 0, rd_pop = 0;
  logic [AW-1:0] pend_addr = '0;

  task automatic check_eq(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe DUT outputs mid-cycle and consume scoreboard entries
  always @(negedge clk) begin : mon
    req_t e;
    if (mem_en) begin
      req_cnt++;
      check_eq("one_outstanding", CL'(pend), CL'(0));
      if (exp_q.size() == 0) begin
        check_eq("req_queued", CL'(exp_q.size()), CL'(1));
      end else begin
        e = exp_q.pop_front();
        check_eq("req_wr", CL'(mem_wr_en), CL'(e.wr));
        check_eq("req_addr", CL'(mem_addr), CL'(e.addr));
        if (e.wr) check_eq("req_wdata", CL'(mem_wdata), CL'(e.data));
      end
      pend      = 1;
      pend_addr = mem_addr;
      lat_cnt   = ack_lat;
    end
    if (dma_rd_en) begin
      rd_cnt++;
      check_eq("rd_not_empty", CL'(dma_empty), CL'(0));
      rd_pop = 1;
    end
    if (dma_wr_en) begin
      wr_cnt++;
      push_cyc = cyc;
      check_eq("push_not_full", CL'(dma_full), CL'(0));
      if (line_q.size() == 0) check_eq("push_queued", CL'(line_q.size()), CL'(1));
      else                    check_eq("push_line", dma_wr_data, line_q.pop_front());
    end
    if (mem_valid) last_ack_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check_eq("done_not_busy", CL'(busy), CL'(0));
    end
  end

  // Host read FIFO and memory responder, updated just after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rd_pop) begin
      if (host_q.size() > 0) host_q.delete(0);
      rd_pop = 0;
    end
    dma_empty   = (host_q.size() == 0);
    dma_rd_data = dma_empty ? '0 : host_q[0];
    mem_valid   = 1'b0;
    if (pend) begin
      if (lat_cnt == 0) begin
        mem_valid = 1'b1;
        mem_rdata = W'(pend_addr);
        pend      = 0;
        reads_acked++;
      end else begin
        lat_cnt--;
      end
    end
  end

  task automatic snap();
    p_req = req_cnt; p_rd = rd_cnt; p_wr = wr_cnt; p_done = done_cnt;
  endtask

  task automatic start_xfer(input bit md, input int n, input logic [AW-1:0] base);
    @(posedge clk); #1;
    start = 1'b1; mode = md; num_lines = CW'(n); mem_base = base; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == p_done && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq(tag, CL'(done_cnt - p_done), CL'(1));
  endtask

  task automatic reset_outs(input string pfx);
    check_eq({pfx, "_busy"},   CL'(busy),      CL'(0));
    check_eq({pfx, "_done"},   CL'(done),      CL'(0));
    check_eq({pfx, "_rd_en"},  CL'(dma_rd_en), CL'(0));
    check_eq({pfx, "_wr_en"},  CL'(dma_wr_en), CL'(0));
    check_eq({pfx, "_mem_en"}, CL'(mem_en),    CL'(0));
    check_eq({pfx, "_mem_we"}, CL'(mem_wr_en), CL'(0));
    check_eq({pfx, "_addr"},   CL'(mem_addr),  CL'(0));
    check_eq({pfx, "_wdata"},  CL'(mem_wdata), CL'(0));
    check_eq({pfx, "_line"},   dma_wr_data,    CL'(0));
  endtask

  task automatic queue_load(input int lines, input logic [AW-1:0] base);
    logic [CL-1:0] l;
    for (int j = 0; j < lines; j++) begin
      for (int k = 0; k < WPL; k++) l[k*W +: W] = $urandom();
      host_q.push_back(l);
      for (int k = 0; k < WPL; k++)
        exp_q.push_back('{1'b1, AW'(base + AW'(j*WPL + k)), l[k*W +: W]});
    end
  endtask

  task automatic queue_store(input int lines, input logic [AW-1:0] base);
    logic [CL-1:0] l;
    logic [AW-1:0] a;
    for (int j = 0; j < lines; j++) begin
      for (int k = 0; k < WPL; k++) begin
        a = AW'(base + AW'(j*WPL + k));
        l[k*W +: W] = W'(a);
        exp_q.push_back('{1'b0, a, '0});
      end
      line_q.push_back(l);
    end
  endtask

  initial begin
    int n, acked0;
    repeat (3) @(posedge clk);
    #1;
    reset_outs("rst");
    rst = 1'b0;

    // LOAD, 2 lines from 0x100
    ack_lat = 0;
    queue_load(2, AW'('h100));
    snap();
    start_xfer(1'b0, 2, AW'('h100));
    check_eq("ld2_busy", CL'(busy), CL'(1));
    wait_done("ld2_done", 400);
    check_eq("ld2_reqs", CL'(req_cnt - p_req), CL'(32));
    check_eq("ld2_rd_pulses", CL'(rd_cnt - p_rd), CL'(2));
    check_eq("ld2_no_push", CL'(wr_cnt - p_wr), CL'(0));
    check_eq("ld2_done_after_ack", CL'(done_cyc - last_ack_cyc), CL'(1));
    check_eq("ld2_exp_left", CL'(exp_q.size()), CL'(0));

    // STORE, 1 line from 0x20
    queue_store(1, AW'('h20));
    snap();
    start_xfer(1'b1, 1, AW'('h20));
    wait_done("st1_done", 300);
    check_eq("st1_reqs", CL'(req_cnt - p_req), CL'(16));
    check_eq("st1_pushes", CL'(wr_cnt - p_wr), CL'(1));
    check_eq("st1_no_pop", CL'(rd_cnt - p_rd), CL'(0));
    check_eq("st1_done_after_push", CL'(done_cyc - push_cyc), CL'(1));
    check_eq("st1_lines_left", CL'(line_q.size()), CL'(0));

    // Zero-line transfers in both modes
    for (int md = 0; md < 2; md++) begin
      snap();
      start_xfer(md[0], 0, AW'('h55));
      check_eq("zero_busy", CL'(busy), CL'(0));
      wait_done("zero_done", 20);
      check_eq("zero_done_lat", CL'(done_cyc - start_cyc), CL'(1));
      check_eq("zero_reqs", CL'(req_cnt - p_req), CL'(0));
      check_eq("zero_rd", CL'(rd_cnt - p_rd), CL'(0));
      check_eq("zero_wr", CL'(wr_cnt - p_wr), CL'(0));
    end

    // STORE with the host write FIFO full for 10 cycles in ST_PUSH
    dma_full = 1'b1;
    queue_store(1, AW'('h40));
    snap();
    acked0 = reads_acked;
    start_xfer(1'b1, 1, AW'('h40));
    n = 0;
    while (reads_acked - acked0 < WPL && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("full_reads", CL'(reads_acked - acked0), CL'(WPL));
    repeat (11) @(posedge clk);
    #1;
    check_eq("full_no_push", CL'(wr_cnt - p_wr), CL'(0));
    check_eq("full_busy", CL'(busy), CL'(1));
    dma_full = 1'b0;
    wait_done("full_done", 50);
    check_eq("full_pushes", CL'(wr_cnt - p_wr), CL'(1));
`ifdef DMA_BRIDGE_PERF_EN
    check_eq("full_stall", CL'(stall_cycles), CL'(10));
`endif

    // LOAD across the top of the address space
    queue_load(1, AW'('hFFFFFFE));
    snap();
    start_xfer(1'b0, 1, AW'('hFFFFFFE));
    wait_done("wrap_done", 200);
    check_eq("wrap_reqs", CL'(req_cnt - p_req), CL'(16));
    check_eq("wrap_exp_left", CL'(exp_q.size()), CL'(0));

    // Reset while a LOAD write is outstanding, then a clean 2-line STORE
    ack_lat = 3;
    queue_load(1, AW'('h500));
    snap();
    start_xfer(1'b0, 1, AW'('h500));
    n = 0;
    while (req_cnt == p_req && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("rst_ld_reached", CL'(req_cnt - p_req), CL'(1));
    rst = 1'b1;
    exp_q.delete();
    host_q.delete();
    @(posedge clk); #1;
    reset_outs("mid_rst");
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("stale_idle", CL'(busy), CL'(0));
    check_eq("stale_no_req", CL'(req_cnt - p_req), CL'(1));
    ack_lat = 1;
    queue_store(2, AW'('h300));
    snap();
    start_xfer(1'b1, 2, AW'('h300));
    wait_done("rst_st_done", 600);
    check_eq("rst_st_reqs", CL'(req_cnt - p_req), CL'(32));
    check_eq("rst_st_pushes", CL'(wr_cnt - p_wr), CL'(2));
    check_eq("rst_st_exp_left", CL'(exp_q.size()), CL'(0));
`ifdef DMA_BRIDGE_PERF_EN
    check_eq("rst_st_stall", CL'(stall_cycles), CL'(32));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
